// File: rtl/regfile_sb.sv
// Dual-read, dual-write register file with a per-register busy scoreboard and a
// sequential clear engine that zeroes one entry per cycle.
module regfile_sb #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int ZERO_R0 = 1
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic [AW-1:0] rna,
   input  logic [AW-1:0] rnb,
   output logic [DW-1:0] qa,
   output logic [DW-1:0] qb,
   output logic          busy_a,
   output logic          busy_b,
   input  logic          we0,
   input  logic [AW-1:0] wn0,
   input  logic [DW-1:0] d0,
   input  logic          we1,
   input  logic [AW-1:0] wn1,
   input  logic [DW-1:0] d1,
   input  logic          iss_v,
   input  logic [AW-1:0] iss_rd,
   input  logic          clr_req,
   output logic          clr_busy
);

   localparam int            N        = 32'd1 << AW;
   localparam bit            ZR       = (ZERO_R0 != 32'sd0);
   localparam logic [AW-1:0] R0       = {AW{1'b0}};
   localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
   localparam logic [AW-1:0] IDX_ONE  = AW'(32'd1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t          state_r;
   logic [AW-1:0]   idx_r;
   logic            clr_busy_r;
   logic [DW-1:0]   mem_r [N];
   logic [N-1:0]    busy_r;
   logic [N-1:0]    busy_upd_s;
   logic            idle_s;
   logic            wr0_s;
   logic            wr1_s;
   logic            iss_s;

   // Gating on clrn keeps the write-first bypass from leaking data while reset is held.
   assign idle_s = clrn && (state_r == IDLE);
   assign wr0_s  = idle_s && we0 && !(ZR && (wn0 == R0));
   assign wr1_s  = idle_s && we1 && !(ZR && (wn1 == R0));
   assign iss_s  = idle_s && iss_v && !(ZR && (iss_rd == R0));

   // Port A read with write-first bypass, port 1 taking priority
   always_comb begin
      qa = mem_r[rna];
      if (ZR && (rna == R0)) begin
         qa = {DW{1'b0}};
      end else if (wr1_s && (wn1 == rna)) begin
         qa = d1;
      end else if (wr0_s && (wn0 == rna)) begin
         qa = d0;
      end else begin
         qa = mem_r[rna];
      end
   end

   // Port B read with write-first bypass, port 1 taking priority
   always_comb begin
      qb = mem_r[rnb];
      if (ZR && (rnb == R0)) begin
         qb = {DW{1'b0}};
      end else if (wr1_s && (wn1 == rnb)) begin
         qb = d1;
      end else if (wr0_s && (wn0 == rnb)) begin
         qb = d0;
      end else begin
         qb = mem_r[rnb];
      end
   end

   assign busy_a   = (ZR && (rna == R0)) ? 1'b0 : busy_r[rna];
   assign busy_b   = (ZR && (rnb == R0)) ? 1'b0 : busy_r[rnb];
   assign clr_busy = clr_busy_r;

   // Next scoreboard state: writes retire a register, a same-cycle issue re-marks it
   always_comb begin
      busy_upd_s = busy_r;
      for (int i = 0; i < N; i++) begin
         busy_upd_s[i] = (iss_s && (iss_rd == AW'(i))) |
                         (busy_r[i] & ~((wr0_s && (wn0 == AW'(i))) |
                                        (wr1_s && (wn1 == AW'(i)))));
      end
   end

   // Register array: async clear, sequential clear, or port 0 then port 1 commit
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < N; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
      end else if (state_r == CLEAR) begin
         mem_r[idx_r] <= {DW{1'b0}};
      end else begin
         if (wr0_s) begin
            mem_r[wn0] <= d0;
         end
         if (wr1_s) begin
            mem_r[wn1] <= d1;
         end
      end
   end

   // Clear sequencer, scoreboard and clr_busy flag
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_r    <= IDLE;
         idx_r      <= R0;
         busy_r     <= {N{1'b0}};
         clr_busy_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (clr_req) begin
                  state_r    <= CLEAR;
                  idx_r      <= R0;
                  busy_r     <= {N{1'b0}};
                  clr_busy_r <= 1'b1;
               end else begin
                  busy_r     <= busy_upd_s;
               end
            end
            CLEAR: begin
               if (idx_r == LAST_IDX) begin
                  state_r    <= IDLE;
                  clr_busy_r <= 1'b0;
               end else begin
                  idx_r      <= idx_r + IDX_ONE;
               end
            end
            default: begin
               state_r    <= IDLE;
               clr_busy_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
